// File: rtl/div_32_bit.sv
// Sequential signed divider, non-restoring, one quotient bit per clock.
// rslt packs {remainder, quotient}; remainder follows the dividend's sign.
module div_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] rslt
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic [CW-1:0]    count;
  logic             sign_q;
  logic             sign_r;
  logic             y_zero;

  logic [WIDTH:0]   x_ext, y_ext, x_abs, y_abs;
  logic [WIDTH:0]   shifted, step_rem, fixed_rem;
  logic [WIDTH-1:0] rem_mag, quo_mag, rem_out, quo_out;

  // 33-bit negate so that the most negative operand yields magnitude 2^31
  always_comb begin
    x_ext = {x[WIDTH-1], x};
    y_ext = {y[WIDTH-1], y};
    x_abs = x[WIDTH-1] ? -x_ext : x_ext;
    y_abs = y[WIDTH-1] ? -y_ext : y_ext;
  end

  always_comb begin
    shifted   = {prem[WIDTH-1:0], quo[WIDTH-1]};
    step_rem  = prem[WIDTH] ? shifted + {1'b0, dvs_mag} : shifted - {1'b0, dvs_mag};
    fixed_rem = prem[WIDTH] ? prem + {1'b0, dvs_mag} : prem;
    // On divide by zero quo still holds |x|, so the signed remainder equals x
    rem_mag   = y_zero ? quo : fixed_rem[WIDTH-1:0];
    quo_mag   = y_zero ? '1 : quo;
    rem_out   = sign_r ? -rem_mag : rem_mag;
    quo_out   = (sign_q && !y_zero) ? -quo_mag : quo_mag;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      prem     <= '0;
      quo      <= '0;
      dvs_mag  <= '0;
      count    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      y_zero   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      rslt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            quo      <= x_abs[WIDTH-1:0];
            dvs_mag  <= y_abs[WIDTH-1:0];
            sign_q   <= x[WIDTH-1] ^ y[WIDTH-1];
            sign_r   <= x[WIDTH-1];
            y_zero   <= (y == '0);
            prem     <= '0;
            count    <= '0;
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state    <= (y == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          prem  <= step_rem;
          quo   <= {quo[WIDTH-2:0], ~step_rem[WIDTH]};
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          rslt     <= {rem_out, quo_out};
          div_zero <= y_zero;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32_bit.sv
// Directed-vector and random checks for the sequential signed divider.
module tb_div_32_bit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        busy, done, div_zero;
  logic [63:0] rslt;

  int passed = 0;
  int total  = 0;

  div_32_bit dut (
    .clock(clock), .clear(clear), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .div_zero(div_zero), .rslt(rslt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] rem;
    logic [31:0] quo;
    logic        dz;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic kick(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    x = a; y = b; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Counts edges from the start edge (lat=1) until done is seen
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clock);
      #1 lat++;
    end
  endtask

  initial begin
    int lat;
    bit seen;
    logic [31:0] rx, ry;
    int sx, sy;
    logic [31:0] eq, er;

    vecs[0]  = '{32'd100,       32'd7,          32'd2,          32'd14,         1'b0};
    vecs[1]  = '{-32'sd100,     32'd7,          32'hFFFFFFFE,   32'hFFFFFFF2,   1'b0};
    vecs[2]  = '{32'd100,       -32'sd7,        32'd2,          32'hFFFFFFF2,   1'b0};
    vecs[3]  = '{-32'sd100,     -32'sd7,        32'hFFFFFFFE,   32'd14,         1'b0};
    vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    vecs[5]  = '{32'h7FFFFFFF,  32'd1,          32'd0,          32'h7FFFFFFF,   1'b0};
    vecs[6]  = '{32'd55,        32'd0,          32'd55,         32'hFFFFFFFF,   1'b1};
    vecs[7]  = '{32'd0,         32'd5,          32'd0,          32'd0,          1'b0};
    vecs[8]  = '{32'h80000000,  32'd2,          32'd0,          32'hC0000000,   1'b0};
    vecs[9]  = '{32'd5,         32'h80000000,   32'd5,          32'd0,          1'b0};
    vecs[10] = '{32'h80000000,  32'h80000000,   32'd0,          32'd1,          1'b0};
    vecs[11] = '{-32'sd7,       32'd0,          32'hFFFFFFF9,   32'hFFFFFFFF,   1'b1};
    vecs[12] = '{32'd20,        32'd6,          32'd2,          32'd3,          1'b0};
    vecs[13] = '{-32'sd1,       32'd2,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[14] = '{32'h80000000,  32'd0,          32'h80000000,   32'hFFFFFFFF,   1'b1};

    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_dz",   {63'd0, div_zero}, 64'd0);
    check("reset_rslt", rslt, 64'd0);
    repeat (2) @(negedge clock);
    clear = 1'b1;

    for (int i = 0; i < 15; i++) begin
      kick(vecs[i].x, vecs[i].y);
      check($sformatf("v%0d_busy_start", i), {63'd0, busy}, 64'd1);
      check($sformatf("v%0d_dz_start", i), {63'd0, div_zero}, 64'd0);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), vecs[i].dz ? 64'd2 : 64'd34);
      check($sformatf("v%0d_rslt", i), rslt, {vecs[i].rem, vecs[i].quo});
      check($sformatf("v%0d_dz", i), {63'd0, div_zero}, {63'd0, vecs[i].dz});
      check($sformatf("v%0d_busy_done", i), {63'd0, busy}, 64'd0);
      @(posedge clock);
      #1 check($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
    end

    // Start while busy is ignored; start in the done cycle is accepted
    kick(32'd100, 32'd7);
    repeat (9) @(posedge clock);
    kick(32'd9, 32'd3);
    wait_done(lat);
    check("ign_rslt", rslt, {32'd2, 32'd14});
    x = 32'd9; y = 32'd3; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check("b2b_busy", {63'd0, busy}, 64'd1);
    check("b2b_done_low", {63'd0, done}, 64'd0);
    check("b2b_rslt_held", rslt, {32'd2, 32'd14});
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'd34);
    check("b2b_rslt", rslt, {32'd0, 32'd3});

    // Asynchronous clear abandons a divide in flight
    kick(32'd100, 32'd7);
    repeat (14) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("clr_busy", {63'd0, busy}, 64'd0);
    check("clr_rslt", rslt, 64'd0);
    check("clr_done", {63'd0, done}, 64'd0);
    @(negedge clock);
    clear = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1 if (done) seen = 1'b1;
    end
    check("clr_no_done", {63'd0, seen}, 64'd0);
    kick(32'd20, 32'd6);
    wait_done(lat);
    check("clr_after_latency", 64'(lat), 64'd34);
    check("clr_after_rslt", rslt, {32'd2, 32'd3});

    // Random signed pairs against the language operators
    for (int n = 0; n < 1000; n++) begin
      rx = $urandom;
      if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(0, 40)) - 32'd20;
      else ry = $urandom;
      if ($urandom_range(0, 7) == 0) rx = 32'($urandom_range(0, 1000)) - 32'd500;
      if (ry == 32'd0) ry = 32'd3;
      if (rx == 32'h80000000 && ry == 32'hFFFFFFFF) ry = 32'd1;
      sx = rx; sy = ry;
      eq = 32'(sx / sy);
      er = 32'(sx % sy);
      kick(rx, ry);
      wait_done(lat);
      check($sformatf("rnd%0d_%h_%h", n, rx, ry), rslt, {er, eq});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_32_bit.md
Name: div_32_bit

Overview:
Sequential signed 32-bit divider. It is the inverse operation of the combinational Booth multiplier in the ALU datapath and produces quotient and remainder for DIV. It uses a non-restoring algorithm that resolves one quotient bit per clock. The 64-bit result uses the multiplier's packing: upper half goes to HI as the remainder, lower half goes to LO as the quotient.

Parameters:
WIDTH, 32, operand width in bits. The result is 2*WIDTH wide. Only 32 is required to be verified.

Ports:
clock  input  1  system clock; all state updates on its rising edge
clear  input  1  asynchronous, active-low reset
start  input  1  request a divide; sampled only in IDLE
x  input  WIDTH  signed dividend
y  input  WIDTH  signed divisor
busy  output  1  high while a divide is in progress
done  output  1  one-cycle pulse when rslt is valid and updated
div_zero  output  1  set with done when y was 0; held until next accepted start
rslt  output  2*WIDTH  {remainder, quotient}; held stable between done pulses

Behaviour:
- Reset: clear low forces IDLE immediately, asynchronously.
  - busy=0, done=0, div_zero=0, rslt=0, iteration count=0.
  - A divide in progress is abandoned and produces no done.
  - After clear is released, the next start is accepted normally.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Latch |x|, |y|, sign_q = x[31]^y[31], sign_r = x[31].
  - Clear the partial remainder (WIDTH+1 bits) and count.
  - busy=1, div_zero cleared.
  - If y==0, go to FIX. Otherwise go to CALC.
- CALC: each edge performs one non-restoring step.
  - Shift {partial remainder, quotient} left by 1.
  - If the partial remainder is >=0, subtract |y|; otherwise add |y|.
  - The new quotient LSB is the inverted sign of the partial remainder.
  - count increments. Leave to FIX after the 32nd step (edge E32).
- FIX (edge E33):
  - If the partial remainder is negative, add |y| (final restore).
  - Apply signs: quotient negated if sign_q; remainder negated if sign_r. Truncation is toward zero and the remainder takes the dividend's sign.
  - Write rslt, pulse done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency:
  - Normal divide: start sampled at E0, done visible after E33, i.e. 34 cycles.
  - Divide by zero: goes E0 -> FIX, done after E1.
- Divide by zero:
  - rslt = {x, 32'hFFFFFFFF}, div_zero=1 with done.
  - No trap is raised; the control unit decides the action.
- Overflow: x=32'h80000000, y=32'hFFFFFFFF gives quotient 32'h80000000 (wraps), remainder 0, div_zero=0.
- Operand magnitude: |x| and |y| are computed with a 33-bit negate so that 32'h80000000 yields magnitude 2^31 correctly.
- start while busy=1 is ignored. x and y may change freely after E0.
- start=1 in the cycle done=1 is accepted, because the block is already in IDLE. The new divide begins at that edge, and rslt keeps its old value until the new done.
- start held high continuously produces back-to-back divides, one every 34 cycles.
- done and busy are never high in the same cycle.

Test Plan:
- x=100, y=7, start pulse -> done exactly 34 cycles after the start edge; rslt={32'd2, 32'd14}; div_zero=0.
- x=-100, y=7 -> quotient 32'hFFFFFFF2, remainder 32'hFFFFFFFE. Then x=100, y=-7 -> quotient 32'hFFFFFFF2, remainder 32'd2.
- x=32'h80000000, y=32'hFFFFFFFF -> rslt={32'h0, 32'h80000000}. Then x=32'h7FFFFFFF, y=1 -> {0, 32'h7FFFFFFF}.
- x=55, y=0 -> done two cycles after start; div_zero=1; rslt={32'd55, 32'hFFFFFFFF}. A following valid start clears div_zero.
- Start 100/7, pulse start with x=9, y=3 at cycle 10 -> ignored; result is {2, 14}. Start 9/3 in the done cycle -> {0, 3} after 34 more cycles.
- Start 100/7, drive clear low at cycle 15 -> busy=0, rslt=0 immediately; no done pulse follows. After release, 20/6 -> {2, 3}.
- Randomised run: 1000 signed pairs checked against the Verilog / and % operators (skipping y=0).
